ras_stack_ctrl: RTL and testbench
=================================

Name: ras_stack_ctrl

Overview:
- Return-address-stack controller; the initiator side of the dual-port `bram` storage block.
- Keeps the top of stack (TOS) in a register, so the current return address is always visible combinationally.
- Spills older entries to `bram` on push and refills the TOS from `bram` on pop.
- Sits between the fetch/branch-prediction logic (push on call, pop on return) and one `bram` instance.

Parameters:
- WIDTH, 32, return-address width in bits.
- ADDR, 4, `bram` address width.
- DEPTH, 16, `bram` entries. Must equal 2**ADDR; elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- push_valid  in  1  push request (call).
- push_data  in  WIDTH  address to push.
- push_ready  out  1  push accepted when push_valid && push_ready.
- pop_valid  in  1  pop request (return).
- pop_ready  out  1  pop accepted when pop_valid && pop_ready.
- top_valid  out  1  TOS register holds a valid entry.
- top_data  out  WIDTH  current TOS; valid only while top_valid=1.
- count  out  ADDR+1  entries held in `bram` (excludes TOS); saturates at DEPTH.
- overflow  out  1  sticky; set when a spill overwrites the oldest entry.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, tos_valid=0, tos=0, wr_ptr=0, count=0, overflow=0.
  - Outputs follow: push_ready=1, pop_ready=0, top_valid=0, top_data=0.
  - `bram` contents are not cleared.
  - Reset mid-REFILL aborts the refill. Late `bram` read data is ignored.
- States:
  - IDLE: accepts traffic.
  - REFILL: waiting one cycle for `bram` read data.
- Handshake:
  - push_ready = (state==IDLE).
  - pop_ready = (state==IDLE) && tos_valid.
  - top_valid = tos_valid && (state==IDLE).
- `bram` usage:
  - Port A is write-only: ena=wea=1 for a spill, addra=wr_ptr, dia=tos.
  - Port B is read-only: enb=1, web=0, addrb=wr_ptr-1.
  - At most one port is enabled per cycle. dib is tied 0.
- Push only, tos_valid=0: tos<=push_data, tos_valid<=1. No `bram` access.
- Push only, tos_valid=1:
  - Spill: `bram`[wr_ptr]<=tos, tos<=push_data, wr_ptr<=wr_ptr+1 (mod DEPTH).
  - If count<DEPTH: count<=count+1.
  - Else: count stays DEPTH and overflow<=1 (circular overwrite of the oldest entry).
- Pop only, count==0: tos_valid<=0. Stack becomes empty. No `bram` access.
- Pop only, count>0:
  - Issue `bram` read at wr_ptr-1; wr_ptr<=wr_ptr-1 (mod DEPTH); count<=count-1; state<=REFILL.
- REFILL: tos<=dob, state<=IDLE.
  - Pop accepted at edge T leaves REFILL for cycle T+1.
  - Refilled TOS is visible (top_valid=1) from T+2.
  - push_ready=pop_ready=0 during REFILL.
- Push and pop accepted in the same cycle (requires tos_valid=1): replace, tos<=push_data. No pointer, count, or `bram` change.
- Pop when empty: impossible, since pop_ready=0. pop_valid is ignored; no state change, no error flag.
- Wrap-around: wr_ptr wraps DEPTH-1 -> 0 on push and 0 -> DEPTH-1 on pop.
  - After an overflow, popping past the overwritten entries returns stale data.
  - This is acceptable for a RAS: prediction only, no correctness impact.
- overflow clears only on rst.

Decomposition:
- Package ras_pkg:
  - state enum (RAS_IDLE, RAS_REFILL).
  - Default WIDTH/ADDR constants.
  - Derived DEPTH = 1<<ADDR.
- One sub-module: `bram` (existing dual-port RAM), instantiated with DEPTH/WIDTH/ADDR passed through.
- Controller FSM, pointer and TOS register live in ras_stack_ctrl itself.

Test Plan (ADDR=2, DEPTH=4, WIDTH=32):
- Reset, then push 0x100 -> next cycle top_valid=1, top_data=0x100, count=0. Pop -> top_valid=0, count=0, no `bram` enable.
- Push 0x100, 0x200, 0x300 back-to-back -> top_data=0x300, count=2. Pop at T -> top_valid=0 and pop_ready=0 at T+1, top_data=0x200 at T+2, count=1.
- Push 0x1..0x6 (6 pushes) -> count=4, overflow=1. Pop 4 times with full REFILL gaps -> tops 0x5, 0x4, 0x3, 0x2. Then count=0, top_data=0x2 still valid.
- With top_data=0xA, count=1: assert push 0xB and pop in one cycle -> top_data=0xB, count=1, no `bram` enable. Next pop refills the prior spilled entry.
- Assert push_valid during REFILL -> push_ready=0, push held. Accepted the first IDLE cycle; resulting top_data = pushed value.
- Assert rst asynchronously mid-REFILL -> outputs clear immediately without a clock edge (top_valid=0, count=0, overflow=0, push_ready=1). After release, first push behaves as the empty-stack case.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types and default sizing for the return-address-stack controller.
package ras_pkg;

  // Controller states: accepting traffic, or waiting on bram read data.
  typedef enum logic {
    RAS_IDLE   = 1'b0,
    RAS_REFILL = 1'b1
  } ras_state_t;

  localparam int RAS_WIDTH = 32;
  localparam int RAS_ADDR  = 4;
  localparam int RAS_DEPTH = 1 << RAS_ADDR;

endpackage

// File: rtl/ras_stack_ctrl_bram.sv
// Simple dual-port block RAM: two address ports, registered read on port B.
// Contents are never reset.
module bram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             ena,
  input  logic             wea,
  input  logic [ADDR-1:0]  addra,
  input  logic [WIDTH-1:0] dia,
  input  logic             enb,
  input  logic             web,
  input  logic [ADDR-1:0]  addrb,
  input  logic [WIDTH-1:0] dib,
  output logic [WIDTH-1:0] dob
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dob;

  // Writes from either port and the registered port-B read share one process.
  always_ff @(posedge clk) begin
    if (ena && wea) begin
      r_mem[addra] <= dia;
    end
    if (enb && web) begin
      r_mem[addrb] <= dib;
    end
    if (enb) begin
      r_dob <= r_mem[addrb];
    end
  end

  assign dob = r_dob;

endmodule

// File: rtl/ras_stack_ctrl.sv
// Return-address-stack controller. The top of stack lives in a register so the
// predicted return address is visible combinationally; older entries spill to
// a circular bram and come back one cycle after a pop.
import ras_pkg::*;

module ras_stack_ctrl #(
  parameter int WIDTH = RAS_WIDTH,
  parameter int ADDR  = RAS_ADDR,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_valid,
  output logic             pop_ready,
  output logic             top_valid,
  output logic [WIDTH-1:0] top_data,
  output logic [ADDR:0]    count,
  output logic             overflow
);

  if (DEPTH != (1 << ADDR)) begin : g_depth_chk
    $error("ras_stack_ctrl: DEPTH must equal 2**ADDR");
  end

  localparam logic [ADDR:0] LP_FULL = (ADDR+1)'(DEPTH);

  ras_state_t       r_state;
  ras_state_t       w_state_next;
  logic             r_tos_valid;
  logic [WIDTH-1:0] r_tos;
  logic [ADDR-1:0]  r_wr_ptr;
  logic [ADDR:0]    r_count;
  logic             r_overflow;

  logic             w_idle;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic             w_spill;
  logic             w_refill_req;
  logic             w_ena;
  logic             w_enb;
  logic [ADDR-1:0]  w_rd_addr;
  logic [WIDTH-1:0] w_dob;

  // Handshake qualifiers; readiness depends on state only, never on inputs.
  assign w_idle       = (r_state == RAS_IDLE);
  assign w_push_acc   = push_valid && w_idle;
  assign w_pop_acc    = pop_valid && w_idle && r_tos_valid;
  assign w_spill      = w_push_acc && !w_pop_acc && r_tos_valid;
  assign w_refill_req = w_pop_acc && !w_push_acc && (r_count != '0);
  assign w_rd_addr    = r_wr_ptr - ADDR'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RAS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a pop with spilled entries waits one cycle for read data.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RAS_IDLE:   if (w_refill_req) w_state_next = RAS_REFILL;
      RAS_REFILL: w_state_next = RAS_IDLE;
      default:    w_state_next = RAS_IDLE;
    endcase
  end

  // Outputs: handshakes, visibility of the TOS and bram port enables.
  always_comb begin
    push_ready = w_idle;
    pop_ready  = w_idle && r_tos_valid;
    top_valid  = w_idle && r_tos_valid;
    w_ena      = w_spill;
    w_enb      = w_refill_req;
  end

  // TOS, spill pointer, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tos_valid <= 1'b0;
      r_tos       <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else if (r_state == RAS_REFILL) begin
      r_tos <= w_dob;
    end else if (w_push_acc && w_pop_acc) begin
      // Call and return together: the new address simply replaces the TOS.
      r_tos <= push_data;
    end else if (w_push_acc) begin
      r_tos       <= push_data;
      r_tos_valid <= 1'b1;
      if (r_tos_valid) begin
        r_wr_ptr <= r_wr_ptr + ADDR'(1);
        if (r_count != LP_FULL) begin
          r_count <= r_count + (ADDR+1)'(1);
        end else begin
          // Full ring: the spill has just overwritten the oldest entry.
          r_overflow <= 1'b1;
        end
      end
    end else if (w_pop_acc) begin
      if (r_count == '0) begin
        r_tos_valid <= 1'b0;
      end else begin
        r_wr_ptr <= w_rd_addr;
        r_count  <= r_count - (ADDR+1)'(1);
      end
    end
  end

  assign top_data = r_tos;
  assign count    = r_count;
  assign overflow = r_overflow;

  bram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_bram (
    .clk   (clk),
    .ena   (w_ena),
    .wea   (w_ena),
    .addra (r_wr_ptr),
    .dia   (r_tos),
    .enb   (w_enb),
    .web   (1'b0),
    .addrb (w_rd_addr),
    .dib   ({WIDTH{1'b0}}),
    .dob   (w_dob)
  );

endmodule

// File: tb/tb_ras_stack_ctrl.sv
// Bench for ras_stack_ctrl at ADDR=2: directed scenarios then random traffic,
// compared against a queue-based model of the stack.
module tb_ras_stack_ctrl;

  localparam int W  = 32;
  localparam int A  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          push_ready;
  logic          pop_valid = 1'b0;
  logic          pop_ready;
  logic          top_valid;
  logic [W-1:0]  top_data;
  logic [A:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Model: top entry, spilled entries (oldest at front), pending refill.
  logic          m_tv;
  logic [W-1:0]  m_tos;
  logic [W-1:0]  m_q[$];
  logic          m_ovf;
  logic          m_busy;
  logic [W-1:0]  m_pend;

  ras_stack_ctrl #(.WIDTH(W), .ADDR(A), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .top_valid  (top_valid),
    .top_data   (top_data),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tv = 1'b0; m_tos = '0; m_q.delete(); m_ovf = 1'b0; m_busy = 1'b0; m_pend = '0;
  endtask

  // Asserted away from any clock edge; outputs must clear with no edge.
  task automatic reset_dut(input string tag);
    rst = 1'b1;
    push_valid = 1'b0;
    pop_valid = 1'b0;
    #1;
    model_reset();
    chk({tag, "_top_valid"}, 64'(top_valid), 64'(0));
    chk({tag, "_top_data"}, 64'(top_data), 64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    chk({tag, "_push_ready"}, 64'(push_ready), 64'(1));
    chk({tag, "_pop_ready"}, 64'(pop_ready), 64'(0));
    $display("reset %s", tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of traffic; called at a falling edge.
  task automatic step(input logic pv, input logic [W-1:0] pd, input logic opv);
    logic pa, oa, e_ena, e_enb;
    push_valid = pv;
    push_data  = pd;
    pop_valid  = opv;
    pa    = pv && !m_busy;
    oa    = opv && !m_busy && m_tv;
    e_ena = pa && !oa && m_tv;
    e_enb = oa && !pa && (m_q.size() > 0);
    #1;
    chk("push_ready", 64'(push_ready), 64'(!m_busy));
    chk("pop_ready", 64'(pop_ready), 64'(!m_busy && m_tv));
    chk("bram_ena", 64'(dut.u_bram.ena), 64'(e_ena));
    chk("bram_enb", 64'(dut.u_bram.enb), 64'(e_enb));
    @(posedge clk);
    if (m_busy) begin
      m_tos = m_pend;
      m_busy = 1'b0;
    end else if (pa && oa) begin
      m_tos = pd;
    end else if (pa) begin
      if (m_tv) begin
        m_q.push_back(m_tos);
        if (m_q.size() > D) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
      end
      m_tos = pd;
      m_tv = 1'b1;
    end else if (oa) begin
      if (m_q.size() == 0) m_tv = 1'b0;
      else begin
        m_pend = m_q.pop_back();
        m_busy = 1'b1;
      end
    end
    @(negedge clk);
    chk("top_valid", 64'(top_valid), 64'(m_tv && !m_busy));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_tv && !m_busy) chk("top_data", 64'(top_data), 64'(m_tos));
    $display("step push=%0b/0x%0h pop=%0b -> top_valid=%0b top=0x%0h count=%0d ovf=%0b",
             pv, pd, opv, top_valid, top_data, count, overflow);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_dut("por");

    // Single entry in the TOS register, then pop to empty.
    step(1'b1, 32'h100, 1'b0);
    chk("single_top", 64'(top_data), 64'h100);
    step(1'b0, 32'h0, 1'b1);

    // Three pushes, pop with refill gap.
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h200, 1'b0);
    step(1'b1, 32'h300, 1'b0);
    chk("three_count", 64'(count), 64'd2);
    step(1'b0, 32'h0, 1'b1);
    chk("refill_top_valid", 64'(top_valid), 64'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("refill_top", 64'(top_data), 64'h200);

    // Overflow: six pushes into a four-entry ring, then drain.
    reset_dut("ovf");
    for (int i = 1; i <= 6; i++) step(1'b1, W'(i), 1'b0);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);
    end
    chk("drain_top", 64'(top_data), 64'h2);

    // Simultaneous push and pop replaces the TOS.
    reset_dut("replace");
    step(1'b1, 32'h9, 1'b0);
    step(1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hB, 1'b1);
    chk("replace_top", 64'(top_data), 64'hB);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("replace_refill", 64'(top_data), 64'h9);

    // Push held off during REFILL, accepted in the next IDLE cycle.
    step(1'b1, 32'hC, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hD, 1'b0);
    step(1'b1, 32'hD, 1'b0);
    chk("held_push_top", 64'(top_data), 64'hD);

    // Asynchronous reset while a refill is outstanding.
    step(1'b1, 32'hE, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    #2;
    reset_dut("mid_refill");
    step(1'b1, 32'h77, 1'b0);
    chk("post_reset_count", 64'(count), 64'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_dut("rand");
      end else begin
        step(($urandom_range(0, 99) < 50), $urandom, ($urandom_range(0, 99) < 40));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
